// File: rtl/alu_pkg.sv
// Shared ToyALU definitions: FSM state encoding, default datapath width and
// the counter-width helper used by the iterative units.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/mul_shift_add_if.sv
// Operand/product handshake bundle for mul_shift_add, plus its FSM state for
// observation.
interface mul_shift_add_if #(
    parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);
    import alu_pkg::*;

    // Valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high. A producer holds valid and data until that edge. The
    // consumer may move ready freely. Ready never depends on valid.
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    state_t             dbg_state;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, dbg_state
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, dbg_state
    );

endinterface

// File: rtl/mul_add_step.sv
// One shift-and-add iteration's adder: WIDTH-bit sum with carry-out, built from
// 4-bit carry-lookahead groups chained group to group.
module mul_add_step #(
    parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int NG = (WIDTH + 3) / 4;
    localparam int PW = NG * 4;

    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW:0]   c;
    logic          cin;
    logic          grp_g;
    logic          grp_p;

    // Group carries are resolved in order inside one process. This keeps the
    // carry chain free of combinational feedback through a shared vector.
    always_comb begin
        g              = '0;
        p              = '0;
        g[WIDTH-1:0]   = x & y;
        p[WIDTH-1:0]   = x ^ y;
        c              = '0;
        cin            = 1'b0;
        grp_g          = 1'b0;
        grp_p          = 1'b0;
        for (int k = 0; k < NG; k++) begin
            c[4*k]     = cin;
            c[4*k+1]   = g[4*k] | (p[4*k] & cin);
            c[4*k+2]   = g[4*k+1] | (p[4*k+1] & g[4*k])
                       | (p[4*k+1] & p[4*k] & cin);
            c[4*k+3]   = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                       | (p[4*k+2] & p[4*k+1] & g[4*k])
                       | (p[4*k+2] & p[4*k+1] & p[4*k] & cin);
            grp_g      = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                       | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                       | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            grp_p      = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
            cin        = grp_g | (grp_p & cin);
        end
        c[PW] = cin;
    end

    assign sum   = p[WIDTH-1:0] ^ c[WIDTH-1:0];
    assign carry = c[WIDTH];

endmodule

// File: rtl/mul_shift_add.sv
// Sequential radix-2 shift-and-add unsigned multiplier. It retires one
// multiplier bit per cycle and presents a 2*WIDTH-bit product.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    mul_shift_add_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] step_sum;
    logic             step_carry;
    logic             last_iter;
    logic             in_ready_c;
    logic             out_valid_c;

    // A clear multiplier bit adds zero. The sum is then acc_hi unchanged,
    // with no carry out.
    assign addend    = acc_lo_q[0] ? mcand_q : '0;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    mul_add_step #(.WIDTH(WIDTH)) u_step (
        .x     (acc_hi_q),
        .y     (addend),
        .sum   (step_sum),
        .carry (step_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The multiplier is consumed from acc_lo's LSB while the growing product
    // shifts in from the top. The adder carry becomes the new MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q  <= bus.a;
                        acc_hi_q <= '0;
                        acc_lo_q <= bus.b;
                        cnt_q    <= '0;
                    end
                end
                CALC: begin
                    {acc_hi_q, acc_lo_q} <= {step_carry, step_sum, acc_lo_q[WIDTH-1:1]};
                    cnt_q                <= cnt_q + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.product   = {acc_hi_q, acc_lo_q};
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mul_shift_add.sv
// Directed and randomized checks of mul_shift_add: latency, exact products,
// backpressure, ignored inputs and mid-operation reset.
module tb_mul_shift_add;
    import alu_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic [63:0] exp_q[$];

    mul_shift_add_if #(.WIDTH(32)) bus ();

    mul_shift_add #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts x*y from IDLE and waits for out_valid without retiring.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [63:0] p, output int lat);
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.a        = 32'h5555_AAAA;
        bus.b        = 32'hAAAA_5555;
        lat          = 0;
        while (!bus.out_valid && lat < 100) begin
            step();
            lat++;
        end
        p = bus.product;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_cmp++;
        if (bus.product !== 64'h0) begin
            n_err++;
            $display("FAIL reset_product: got %h expected 0", bus.product);
        end
        n_cmp++;
        if (bus.dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected %0d", bus.dbg_state, IDLE);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int early;
        bus.out_ready = 1'b1;
        bus.a         = 32'd3;
        bus.b         = 32'd5;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy: in_ready got %b expected 0", bus.in_ready);
        end
        early = 0;
        for (int i = 1; i < 32; i++) begin
            step();
            if (bus.out_valid !== 1'b0) early++;
        end
        n_cmp++;
        if (early !== 0) begin
            n_err++;
            $display("FAIL basic_early_valid: got %0d cycles expected 0", early);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL basic_latency: out_valid got %b expected 1 at 32 cycles", bus.out_valid);
        end
        n_cmp++;
        if (bus.product !== 64'h0000_0000_0000_000F) begin
            n_err++;
            $display("FAIL basic_product: got %h expected 000000000000000f", bus.product);
        end
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL basic_retire: out_valid/in_ready got %b/%b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_corner(input string name, input logic [31:0] x,
                               input logic [31:0] y, input logic [63:0] exp);
        logic [63:0] p;
        int          lat;
        bus.out_ready = 1'b1;
        run_op(x, y, p, lat);
        n_cmp++;
        if (lat !== 32) begin
            n_err++;
            $display("FAIL %s_latency: got %0d expected 32", name, lat);
        end
        n_cmp++;
        if (p !== exp) begin
            n_err++;
            $display("FAIL %s_product: got %h expected %h", name, p, exp);
        end
        step();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad_ready;
        int bad_hold;
        int bad_idle;
        bus.out_ready = 1'b0;
        bus.a         = 32'h0001_0000;
        bus.b         = 32'h0001_0000;
        bus.in_valid  = 1'b1;
        step();
        lat       = 0;
        bad_ready = 0;
        while (!bus.out_valid && lat < 100) begin
            bus.in_valid = (lat % 3 == 0);
            bus.a        = 32'd7;
            bus.b        = 32'd9;
            if (bus.in_ready !== 1'b0) bad_ready++;
            step();
            lat++;
        end
        n_cmp++;
        if (lat !== 32) begin
            n_err++;
            $display("FAIL bp_latency: got %0d expected 32", lat);
        end
        n_cmp++;
        if (bad_ready !== 0) begin
            n_err++;
            $display("FAIL bp_calc_in_ready: got %0d high cycles expected 0", bad_ready);
        end
        bad_hold = 0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.a        = 32'd11;
            bus.b        = 32'd13;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.product !== 64'h0000_0001_0000_0000) bad_hold++;
            step();
        end
        n_cmp++;
        if (bad_hold !== 0) begin
            n_err++;
            $display("FAIL bp_hold: got %0d bad cycles expected 0", bad_hold);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.product !== 64'h0000_0001_0000_0000) begin
            n_err++;
            $display("FAIL bp_still_held: out_valid %b product %h expected 1 / 0000000100000000",
                     bus.out_valid, bus.product);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_retire: out_valid/in_ready got %b/%b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
        bad_idle = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid !== 1'b0 || bus.dbg_state !== IDLE) bad_idle++;
            step();
        end
        n_cmp++;
        if (bad_idle !== 0 || bus.product !== 64'h0000_0001_0000_0000) begin
            n_err++;
            $display("FAIL bp_no_ghost_op: bad cycles %0d product %h expected 0 / 0000000100000000",
                     bad_idle, bus.product);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b1;
        bus.a         = 32'hDEAD_BEEF;
        bus.b         = 32'h0000_1234;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_handshake: out_valid/in_ready got %b/%b expected 0/1",
                     bus.out_valid, bus.in_ready);
        end
        n_cmp++;
        if (bus.product !== 64'h0) begin
            n_err++;
            $display("FAIL midrst_product: got %h expected 0", bus.product);
        end
        n_cmp++;
        if (bus.dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL midrst_state: got %0d expected %0d", bus.dbg_state, IDLE);
        end
        test_corner("after_rst_7x6", 32'd7, 32'd6, 64'd42);
    endtask

    task automatic test_back_to_back();
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] e;
        int          gap;
        int          cyc;
        bit          taken;
        for (int n = 0; n < 1000; n++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                step();
            end
            x = $urandom;
            y = $urandom;
            if (n == 0) x = 32'hFFFF_FFFF;
            exp_q.push_back({32'h0, x} * {32'h0, y});
            bus.a        = x;
            bus.b        = y;
            bus.in_valid = 1'b1;
            step();
            taken = 1'b0;
            cyc   = 0;
            while (!taken && cyc < 200) begin
                bus.in_valid  = 1'($urandom_range(0, 1));
                bus.a         = $urandom;
                bus.b         = $urandom;
                bus.out_ready = 1'($urandom_range(0, 1));
                if (bus.out_valid && bus.out_ready) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rand_duplicate: product %h with nothing outstanding", bus.product);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.product !== e) begin
                            n_err++;
                            $display("FAIL rand_product[%0d]: got %h expected %h", n, bus.product, e);
                        end
                    end
                    taken = 1'b1;
                end
                step();
                cyc++;
            end
            bus.in_valid = 1'b0;
            if (!taken) begin
                n_cmp++;
                n_err++;
                $display("FAIL rand_timeout[%0d]: no product within 200 cycles", n);
            end
        end
        bus.out_ready = 1'b1;
        step();
        n_cmp++;
        if (exp_q.size() !== 0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rand_drain: outstanding %0d out_valid %b expected 0/0",
                     exp_q.size(), bus.out_valid);
        end
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_corner("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        test_corner("zero", 32'h0, 32'h1234_5678, 64'h0);
        test_corner("one", 32'h1, 32'h8000_0001, 64'h0000_0000_8000_0001);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_shift_add.md
Name: mul_shift_add

Overview:
- Sequential radix-2 shift-and-add unsigned multiplier for the ToyALU datapath.
- Sits directly upstream of the carry-lookahead adder chain. Each cycle it drives the adder's operands with the partial product and multiplicand, then consumes the sum and carry.
- Produces a 2*WIDTH-bit product behind a valid/ready handshake on each side.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b are valid this cycle.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  multiplicand, unsigned.
- b  input  WIDTH  multiplier, unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer takes the product this cycle.
- product  output  2*WIDTH  a*b, unsigned.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE, in_ready=1, out_valid=0, product=0, counter=0, internal registers=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid at an edge: mcand<=a, acc_hi<=0, acc_lo<=b, cnt<=0, go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each edge: if acc_lo[0], {c,s}=acc_hi+mcand (WIDTH+1 bits, carry kept); otherwise {c,s}={0,acc_hi}.
  - Then {acc_hi,acc_lo}<={c,s,acc_lo[WIDTH-1:1]} (right shift by one, carry enters the MSB). cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge, that iteration completes and the state moves to DONE.
- DONE:
  - out_valid=1, product={acc_hi,acc_lo}, in_ready=0.
  - On out_ready at an edge: go to IDLE. product keeps its value until the next accept; out_valid drops.
- Latency: out_valid rises exactly WIDTH edges after the accept edge, i.e. 32 cycles at the default.
  - Throughput: one operation per WIDTH+2 cycles minimum (accept, WIDTH iterations, retire).
  - No overlap between operations.
- Operands a/b are sampled only at the accept edge; changes afterwards have no effect.
- in_valid in CALC or DONE is ignored and not queued.
- Backpressure: out_ready=0 in DONE holds out_valid=1 and product stable indefinitely.
- out_ready while out_valid=0 has no effect.
- Arithmetic: the carry from acc_hi+mcand is never dropped. The product is exact for all WIDTH-bit inputs, with no overflow possible.
- Reset mid-CALC or mid-DONE aborts the operation; no partial product is ever presented with out_valid=1.
- rst has priority over every other input at the same edge.

Decomposition:
- Shared package (alu_pkg):
  - state enum {IDLE, CALC, DONE}.
  - Default WIDTH constant.
  - A clog2-based helper for CNT_W.
- One natural sub-module, mul_add_step: combinational WIDTH-bit add producing {carry, sum}, built on the team's carry-lookahead adder cells.
  - All registers, the FSM and the counter stay in mul_shift_add.

Test Plan:
- 3*5, out_ready=1 -> product=0x0000_0000_0000_000F; out_valid exactly 32 cycles after the accept edge, high for one cycle; in_ready=1 the following cycle.
- 0xFFFF_FFFF*0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001 (checks carry into acc_hi MSB).
- 0*0x1234_5678 -> 0, and 1*0x8000_0001 -> 0x0000_0000_8000_0001; both take the full 32-cycle latency.
- Backpressure: 0x10000*0x10000 with out_ready=0 for 10 cycles after out_valid.
  - Inject in_valid pulses with other operands during CALC and DONE.
  - Required: product=0x0000_0001_0000_0000 held stable, in_ready=0 throughout.
  - On out_ready=1: IDLE, in_ready=1 next cycle, injected operands never processed.
- Reset at iteration 10 of 0xDEAD_BEEF*0x1234: next cycle out_valid=0, in_ready=1, product=0.
  - Then 7*6 -> 42 after 32 cycles.
- 1000 random operand pairs with random out_ready/in_valid gaps vs a 64-bit golden model: every result exact, no dropped or duplicated outputs.
